decode_unit: RTL
================

# decode_unit

Parametrised RV32I decode stage with an integrated register file, write-back bypass, load-use stall detection and a valid/ready-registered ID/EX output. It sits between fetch (upstream valid/ready) and execute (downstream valid/ready). Compared with the single-width combinational decode, it adds configurable data width and register count, immediate generation, illegal-instruction flagging, pipeline flush and a stall counter.

## Interface
- XLEN, 32: data and PC width; must be ≥ 32.
- REG_COUNT, 32: number of architectural registers; 16 (RV32E) or 32.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- wb_en  in  1  register-file write enable.
- wb_rd  in  5  write register index.
- wb_data  in  XLEN  write data.
- ex_load_valid  in  1  execute currently holds a load.
- ex_load_rd  in  5  destination register of that load.
- flush  in  1  kill the decoded instruction and refuse input.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute accepts the ID/EX contents.
- out_pc  out  XLEN  registered PC.
- out_rs1_data, out_rs2_data  out  XLEN each  operand values.
- out_imm  out  XLEN  sign-extended immediate.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_illegal  out  1  instruction is unsupported or malformed.
- stall_count  out  32  saturating count of hazard-stall cycles.

## Operation
- Supported opcodes: 0110011 R, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
- Immediate format by opcode:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - R: 0.
  - All immediates are sign-extended from instr[31] to XLEN.
- out_illegal = 1 if:
  - the opcode is unsupported, or
  - any used register index (rd, rs1, rs2) is ≥ REG_COUNT.
  - An illegal instruction still flows through the pipe with out_illegal set.
- Register use:
  - rs1 is used by R, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by R, STORE, BRANCH.
  - Unused register ports read 0.
- Register file:
  - REG_COUNT × XLEN entries.
  - Synchronous write when wb_en = 1, wb_rd ≠ 0 and wb_rd < REG_COUNT.
  - Combinational read.
  - x0 always reads 0; writes to x0 are ignored.
- Bypass: if wb_en = 1, wb_rd ≠ 0 and wb_rd == rsN in the same cycle, operand N takes wb_data.
- Hazard: asserted when all of the following hold:
  - ex_load_valid = 1 and ex_load_rd ≠ 0;
  - the instruction uses rs1 with rs1 == ex_load_rd, or uses rs2 with rs2 == ex_load_rd.
- Accept rule: in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Transfer occurs when in_valid & in_ready: all out_* fields are captured and out_valid is set to 1 on the next edge.
- If there is no transfer and out_ready = 1, out_valid is cleared to 0.
- If there is no transfer and out_ready = 0, all out_* fields hold.
- flush has priority over everything: out_valid is cleared to 0 on the next edge and nothing is captured. wb writes still occur during flush.
- stall_count increments by 1 on each edge where in_valid & hazard & !flush. It saturates at 0xFFFFFFFF.

## Timing
- Reset (asynchronous, immediate):
  - out_valid = 0.
  - All out_* fields = 0.
  - stall_count = 0.
  - All register-file entries = 0.
- Latency: an instruction accepted at edge N appears on out_* after edge N (one cycle).
- A register written at edge N is visible to a read at cycle N through the bypass, and from the register array from cycle N+1 onward.
- Output fields are stable while out_valid & !out_ready.
- in_ready is combinational from out_ready, ex_load_*, flush and in_instr.
- Throughput is one instruction per cycle with out_ready held at 1 and no hazards.
- Reset asserted mid-stream discards the in-flight instruction. No partial state survives reset.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready = 1 → the next cycle shows:
  - out_valid = 1
  - out_imm = 0x00000005
  - out_rd = 1
  - out_opcode = 0x13
  - out_illegal = 0
- add x3,x2,x2 (0x002101B3) presented in the same cycle as wb_en = 1, wb_rd = 2, wb_data = 0xDEADBEEF → out_rs1_data = out_rs2_data = 0xDEADBEEF.
- Load-use stall: ex_load_valid = 1, ex_load_rd = 2 for 3 cycles while 0x002101B3 is presented →
  - in_ready = 0 and stall_count = 3 during the stall;
  - the instruction is accepted on the cycle after ex_load_valid drops.
- Backpressure and flush:
  - Hold out_ready = 0 for 4 cycles after an accept → out_* remain constant and in_ready = 0.
  - Then assert flush → out_valid = 0 the next cycle.
- beq x0,x0,-4 (0xFE000EE3) → out_imm = 0xFFFFFFFC.
- 0xFFFFFFFF → out_illegal = 1.
- With REG_COUNT = 16, addi x17,x0,1 (0x00100893) → out_illegal = 1.
- wb_en = 1 with wb_rd = 0 and wb_data = 0x1234, then add x3,x0,x0 (0x000001B3) → out_rs1_data = 0.

Source files
------------

// File: rtl/decode_unit.sv
// RV32I decode stage: register file, write-back bypass, load-use hazard stall, ID/EX output register.
// Latency: one cycle from an accepted instruction to out_*; register reads are combinational.
// Backpressure: in_ready drops on a held ID/EX slot, a load-use hazard or flush; out_* hold while out_valid & !out_ready.
//
// Ports: clk/reset_n (async active-low); in_valid/in_ready/in_instr/in_pc from fetch;
// wb_en/wb_rd/wb_data write-back; ex_load_valid/ex_load_rd load-use hazard source; flush;
// out_valid/out_ready plus decoded out_* fields toward execute; stall_count saturating hazard counter.
module decode_unit #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal,
    output logic [31:0]     stall_count
);

    localparam int         IDX_W     = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [XLEN-1:0] rf [REG_COUNT];

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            supported;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            illegal;
    logic            hazard;
    logic            take;
    logic            wb_write;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    always_comb begin
        supported = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        imm32     = '0;
        case (opcode)
            OPC_OP: begin
                supported = 1'b1;
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                supported = 1'b1;
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                supported = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                supported = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm32     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                supported = 1'b1;
                use_rd    = 1'b1;
                imm32     = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                supported = 1'b1;
                use_rd    = 1'b1;
                imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // imm32 already carries instr[31] in its top bit, so widening it as signed
    // gives the sign extension to XLEN.
    assign dec_imm = XLEN'($signed(imm32));

    assign illegal = !supported
                   | (use_rd  & ({1'b0, rd}  >= REG_LIMIT))
                   | (use_rs1 & ({1'b0, rs1} >= REG_LIMIT))
                   | (use_rs2 & ({1'b0, rs2} >= REG_LIMIT));

    // Same-cycle write-back wins over the array; x0 and out-of-range indices read zero.
    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == idx))
            return wb_data;
        else if ((idx == 5'd0) || ({1'b0, idx} >= REG_LIMIT))
            return '0;
        else
            return rf[idx[IDX_W-1:0]];
    endfunction

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (use_rs1)
            rs1_val = read_reg(rs1);
        if (use_rs2)
            rs2_val = read_reg(rs2);
    end

    assign hazard = ex_load_valid && (ex_load_rd != 5'd0)
                  && ((use_rs1 && (rs1 == ex_load_rd)) || (use_rs2 && (rs2 == ex_load_rd)));

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign take     = in_valid && in_ready;
    assign wb_write = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < REG_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                rf[i] <= '0;
        end else if (wb_write) begin
            rf[wb_rd[IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_data <= rs1_val;
            out_rs2_data <= rs2_val;
            out_imm      <= dec_imm;
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_rd       <= rd;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_illegal  <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (in_valid && hazard && !flush && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

endmodule
